// File: rtl/io_responder.sv
// io_responder: peripheral endpoint of the CPU 8-bit IO port.
// Decodes IO writes into a small command protocol, buffers outbound bytes in a
// transmit FIFO (valid/ready source) and inbound bytes in a receive FIFO
// (valid/ready sink). IO reads return either a status byte or the RX head.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_CMD  | next iow byte is a command (0x01..0x04, others ignored)
//   ST_DATA | next iow byte is pushed into the TX FIFO, then back to CMD
//
// Status byte: {tx_ovf, rx_unf, 2'b00, tx_full, tx_empty, rx_full, rx_empty}
module io_responder #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iow,
  input  logic [7:0] ioout,
  input  logic       ior,
  output logic [7:0] ioin,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  typedef enum logic {ST_CMD, ST_DATA} state_e;
  typedef enum logic {SEL_STATUS, SEL_RXDATA} rsel_e;

  state_e        state_q, state_d;
  rsel_e         rsel_q, rsel_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];

  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          cmd_wr, data_wr, flush;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          rd_stat, rd_rx;
  logic [7:0]    status_byte;

  // Full/empty come from start-of-cycle pointers, so same-cycle pops never
  // make room for a push and same-cycle pushes never satisfy a pop.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]) && (tx_wr_q[AW] != tx_rd_q[AW]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]) && (rx_wr_q[AW] != rx_rd_q[AW]);

  assign cmd_wr  = iow && (state_q == ST_CMD);
  assign data_wr = iow && (state_q == ST_DATA);
  assign flush   = cmd_wr && (ioout == 8'h04);

  assign tx_push = data_wr && !tx_full;
  assign tx_pop  = !tx_empty && tx_ready;
  assign rx_push = rx_valid && !rx_full;

  // Reads decode against the pre-write select, even when a command lands
  // in the same cycle.
  assign rd_stat = ior && (rsel_q == SEL_STATUS);
  assign rd_rx   = ior && (rsel_q == SEL_RXDATA);
  assign rx_pop  = rd_rx && !rx_empty;

  assign status_byte = {tx_ovf_q, rx_unf_q, 2'b00, tx_full, tx_empty, rx_full, rx_empty};

  assign ioin     = (rsel_q == SEL_STATUS) ? status_byte
                  : (rx_empty ? 8'h00 : rx_mem[rx_rd_q[AW-1:0]]);
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_q[AW-1:0]];
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  // Next-state: command decode, pointer advance, sticky flags; flush last so it wins.
  always_comb begin
    state_d  = state_q;
    rsel_d   = rsel_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;

    unique case (state_q)
      ST_CMD: begin
        if (iow) begin
          case (ioout)
            8'h01:   state_d = ST_DATA;
            8'h02:   rsel_d  = SEL_STATUS;
            8'h03:   rsel_d  = SEL_RXDATA;
            default: state_d = ST_CMD;
          endcase
        end
      end
      ST_DATA: begin
        if (iow) state_d = ST_CMD;
      end
      default: state_d = ST_CMD;
    endcase

    if (tx_push) tx_wr_d = tx_wr_q + PW'(1);
    if (tx_pop)  tx_rd_d = tx_rd_q + PW'(1);
    if (rx_push) rx_wr_d = rx_wr_q + PW'(1);
    if (rx_pop)  rx_rd_d = rx_rd_q + PW'(1);

    // A clear by status read loses to a set event in the same cycle.
    if (rd_stat) begin
      tx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end
    if (data_wr && tx_full)  tx_ovf_d = 1'b1;
    if (rd_rx && rx_empty)   rx_unf_d = 1'b1;

    if (flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      tx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CMD;
      rsel_q   <= SEL_STATUS;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rsel_q   <= rsel_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  // FIFO storage; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (!rst && tx_push) tx_mem[tx_wr_q[AW-1:0]] <= ioout;
    if (!rst && rx_push) rx_mem[rx_wr_q[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed vector table, hand-written wrap sequences,
// then random stimulus compared against a queue-based reference model.
module tb_io_responder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iow = 1'b0;
  logic [7:0] ioout = 8'h00;
  logic       ior = 1'b0;
  logic [7:0] ioin;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;

  int n_tests = 0;
  int n_fail  = 0;

  io_responder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .iow(iow), .ioout(ioout), .ior(ior), .ioin(ioin),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  // Reference model: FIFOs as queues, applied with start-of-cycle decisions.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit m_data = 0, m_sel = 0, m_ovf = 0, m_unf = 0;

  always @(posedge clk) begin : model
    int ntx, nrx;
    if (rst) begin
      tx_q.delete(); rx_q.delete();
      m_data = 0; m_sel = 0; m_ovf = 0; m_unf = 0;
    end else begin
      ntx = tx_q.size();
      nrx = rx_q.size();
      if (ior && !m_sel) begin m_ovf = 0; m_unf = 0; end
      if (ior && m_sel) begin
        if (nrx == 0) m_unf = 1;
        else void'(rx_q.pop_front());
      end
      if (tx_ready && ntx > 0) void'(tx_q.pop_front());
      if (rx_valid && nrx < DEPTH) rx_q.push_back(rx_data);
      if (iow && m_data) begin
        if (ntx < DEPTH) tx_q.push_back(ioout);
        else m_ovf = 1;
        m_data = 0;
      end else if (iow) begin
        case (ioout)
          8'h01: m_data = 1;
          8'h02: m_sel = 0;
          8'h03: m_sel = 1;
          8'h04: begin tx_q.delete(); rx_q.delete(); m_ovf = 0; m_unf = 0; end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [7:0] m_ioin();
    if (!m_sel)
      return {m_ovf, m_unf, 2'b00, tx_q.size() == DEPTH, tx_q.size() == 0,
              rx_q.size() == DEPTH, rx_q.size() == 0};
    return (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] wd, input logic rd,
                       input logic tr, input logic rv, input logic [7:0] rdat);
    rst = r; iow = w; ioout = wd; ior = rd; tx_ready = tr; rx_valid = rv; rx_data = rdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r, w;
    logic [7:0] wd;
    logic       rd, tr, rv;
    logic [7:0] rdat;
    logic [7:0] e_ioin;
    logic       e_txv;
    logic [7:0] e_txd;
    logic       e_rxr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic w, input logic [7:0] wd, input logic rd,
                     input logic tr, input logic rv, input logic [7:0] rdat,
                     input logic [7:0] e_ioin, input logic e_txv, input logic [7:0] e_txd,
                     input logic e_rxr);
    vec_t v;
    v.r = r; v.w = w; v.wd = wd; v.rd = rd; v.tr = tr; v.rv = rv; v.rdat = rdat;
    v.e_ioin = e_ioin; v.e_txv = e_txv; v.e_txd = e_txd; v.e_rxr = e_rxr;
    vq.push_back(v);
  endtask

  initial begin
    // Each row: inputs for one cycle, outputs expected after that edge.
    //  r  w  wd     rd tr rv rdat   ioin   txv txd    rxr
    // reset
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    // single TX byte, held then accepted
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(0, 1, 8'hA5, 0, 0, 0, 8'h00, 8'h01, 1, 8'hA5, 1);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 1, 8'hA5, 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    // five pushes into a 4-deep FIFO -> overflow
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(0, 1, 8'h10, 0, 0, 0, 8'h00, 8'h01, 1, 8'h10, 1);
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 8'h10, 1);
    add(0, 1, 8'h11, 0, 0, 0, 8'h00, 8'h01, 1, 8'h10, 1);
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 8'h10, 1);
    add(0, 1, 8'h12, 0, 0, 0, 8'h00, 8'h01, 1, 8'h10, 1);
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 8'h10, 1);
    add(0, 1, 8'h13, 0, 0, 0, 8'h00, 8'h09, 1, 8'h10, 1);
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h09, 1, 8'h10, 1);
    add(0, 1, 8'h14, 0, 0, 0, 8'h00, 8'h89, 1, 8'h10, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h09, 1, 8'h10, 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h01, 1, 8'h11, 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h01, 1, 8'h12, 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h01, 1, 8'h13, 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    // refill, then overflow set beats same-cycle status clear
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(0, 1, 8'h20, 0, 0, 0, 8'h00, 8'h01, 1, 8'h20, 1);
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 8'h20, 1);
    add(0, 1, 8'h21, 0, 0, 0, 8'h00, 8'h01, 1, 8'h20, 1);
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 8'h20, 1);
    add(0, 1, 8'h22, 0, 0, 0, 8'h00, 8'h01, 1, 8'h20, 1);
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 1, 8'h20, 1);
    add(0, 1, 8'h23, 0, 0, 0, 8'h00, 8'h09, 1, 8'h20, 1);
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h09, 1, 8'h20, 1);
    add(0, 1, 8'h24, 1, 0, 0, 8'h00, 8'h89, 1, 8'h20, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h09, 1, 8'h20, 1);
    // push to a full FIFO is rejected even with a same-cycle pop
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h09, 1, 8'h20, 1);
    add(0, 1, 8'h25, 0, 1, 0, 8'h00, 8'h81, 1, 8'h21, 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h81, 1, 8'h22, 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h81, 1, 8'h23, 1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h85, 0, 8'h00, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    // iow 0x03 with ior: read uses STATUS select, so no underflow
    add(0, 1, 8'h03, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    add(0, 1, 8'h02, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    // RX data path and underflow
    add(0, 0, 8'h00, 0, 0, 1, 8'h33, 8'h04, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 1, 8'h44, 8'h04, 0, 8'h00, 1);
    add(0, 1, 8'h03, 0, 0, 0, 8'h00, 8'h33, 0, 8'h00, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h44, 0, 8'h00, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    add(0, 1, 8'h02, 0, 0, 0, 8'h00, 8'h45, 0, 8'h00, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    // RX full: 5th byte refused
    add(0, 0, 8'h00, 0, 0, 1, 8'h01, 8'h04, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 1, 8'h02, 8'h04, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 1, 8'h03, 8'h04, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 1, 8'h04, 8'h06, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 1, 8'h05, 8'h06, 0, 8'h00, 0);
    add(0, 1, 8'h03, 0, 0, 0, 8'h00, 8'h01, 0, 8'h00, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h02, 0, 8'h00, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h03, 0, 8'h00, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h04, 0, 8'h00, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    add(0, 1, 8'h02, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    // fill RX, flush with a same-cycle (refused) offer
    add(0, 0, 8'h00, 0, 0, 1, 8'hC1, 8'h04, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 1, 8'hC2, 8'h04, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 1, 8'hC3, 8'h04, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 1, 8'hC4, 8'h06, 0, 8'h00, 0);
    add(0, 1, 8'h04, 0, 0, 1, 8'hC5, 8'h05, 0, 8'h00, 1);
    // flush beats same-cycle RX push and TX pop
    add(0, 0, 8'h00, 0, 0, 1, 8'hAA, 8'h04, 0, 8'h00, 1);
    add(0, 1, 8'h04, 0, 0, 1, 8'hBB, 8'h05, 0, 8'h00, 1);
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(0, 1, 8'h99, 0, 0, 0, 8'h00, 8'h01, 1, 8'h99, 1);
    add(0, 1, 8'h04, 0, 1, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    // reset between command 0x01 and its data byte
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(0, 1, 8'h77, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    // reset overrides a simultaneous data write
    add(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(1, 1, 8'h99, 1, 1, 1, 8'h5A, 8'h05, 0, 8'h00, 1);
    add(0, 1, 8'h77, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1);

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].w, vq[i].wd, vq[i].rd, vq[i].tr, vq[i].rv, vq[i].rdat);
      tick();
      chk($sformatf("v%0d ioin", i), ioin, vq[i].e_ioin);
      chk($sformatf("v%0d tx_valid", i), {7'd0, tx_valid}, {7'd0, vq[i].e_txv});
      if (vq[i].e_txv || vq[i].r) chk($sformatf("v%0d tx_data", i), tx_data, vq[i].e_txd);
      chk($sformatf("v%0d rx_ready", i), {7'd0, rx_ready}, {7'd0, vq[i].e_rxr});
    end

    // TX pointer wrap: 3*DEPTH+2 sequential single-byte transfers
    for (int i = 0; i < 3 * DEPTH + 2; i++) begin
      drive(0, 1, 8'h01, 0, 0, 0, 8'h00); tick();
      drive(0, 1, 8'hC0 + 8'(i), 0, 0, 0, 8'h00); tick();
      chk($sformatf("txwrap%0d data", i), tx_data, 8'hC0 + 8'(i));
      drive(0, 0, 8'h00, 0, 1, 0, 8'h00); tick();
      chk($sformatf("txwrap%0d valid", i), {7'd0, tx_valid}, 8'h00);
    end

    // RX pointer wrap
    drive(0, 1, 8'h03, 0, 0, 0, 8'h00); tick();
    for (int i = 0; i < 3 * DEPTH + 2; i++) begin
      drive(0, 0, 8'h00, 0, 0, 1, 8'h50 + 8'(i)); tick();
      chk($sformatf("rxwrap%0d head", i), ioin, 8'h50 + 8'(i));
      drive(0, 0, 8'h00, 1, 0, 0, 8'h00); tick();
      chk($sformatf("rxwrap%0d empty", i), ioin, 8'h00);
    end
    drive(0, 1, 8'h02, 0, 0, 0, 8'h00); tick();
    chk("rxwrap status", ioin, 8'h05);

    // Random stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1),
            8'($urandom));
      tick();
      chk($sformatf("rnd%0d ioin", i), ioin, m_ioin());
      chk($sformatf("rnd%0d tx_valid", i), {7'd0, tx_valid}, {7'd0, tx_q.size() != 0});
      if (tx_q.size() != 0) chk($sformatf("rnd%0d tx_data", i), tx_data, tx_q[0]);
      chk($sformatf("rnd%0d rx_ready", i), {7'd0, rx_ready}, {7'd0, rx_q.size() < DEPTH});
    end

    drive(0, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
